// File: rtl/wb_cmd_master.sv
// Command/response to Wishbone B4 classic single-transfer master.
// One transfer in flight at a time; bus hangs are cut off by an optional timeout.
module wb_cmd_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic                    cmd_we_i,
   input  logic [ADDR_WIDTH-1:0]   cmd_adr_i,
   input  logic [DATA_WIDTH-1:0]   cmd_dat_i,
   input  logic [DATA_WIDTH/8-1:0] cmd_sel_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_dat_o,
   output logic                    rsp_err_o,
   output logic                    rsp_timeout_o,
   output logic                    cyc_o,
   output logic                    stb_o,
   output logic                    we_o,
   output logic [ADDR_WIDTH-1:0]   adr_o,
   output logic [DATA_WIDTH-1:0]   dat_o,
   output logic [DATA_WIDTH/8-1:0] sel_o,
   input  logic [DATA_WIDTH-1:0]   dat_i,
   input  logic                    ack_i,
   input  logic                    err_i
);

   // A zero TIMEOUT still needs a 1-bit counter so the declaration stays legal.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;

   assign cmd_ready_o = (state_reg == IDLE) && !rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         cyc_o         <= 1'b0;
         stb_o         <= 1'b0;
         we_o          <= 1'b0;
         adr_o         <= '0;
         dat_o         <= '0;
         sel_o         <= '0;
         rsp_valid_o   <= 1'b0;
         rsp_err_o     <= 1'b0;
         rsp_timeout_o <= 1'b0;
         rsp_dat_o     <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (cmd_valid_i) begin
                  we_o      <= cmd_we_i;
                  adr_o     <= cmd_adr_i;
                  dat_o     <= cmd_dat_i;
                  sel_o     <= cmd_sel_i;
                  cyc_o     <= 1'b1;
                  stb_o     <= 1'b1;
                  cnt_reg   <= '0;
                  state_reg <= BUS;
               end
            end
            BUS: begin
               // Priority: err over ack, any bus response over the timeout.
               if (err_i) begin
                  cyc_o         <= 1'b0;
                  stb_o         <= 1'b0;
                  rsp_valid_o   <= 1'b1;
                  rsp_err_o     <= 1'b1;
                  rsp_timeout_o <= 1'b0;
                  rsp_dat_o     <= '0;
                  state_reg     <= RESP;
               end else if (ack_i) begin
                  cyc_o         <= 1'b0;
                  stb_o         <= 1'b0;
                  rsp_valid_o   <= 1'b1;
                  rsp_err_o     <= 1'b0;
                  rsp_timeout_o <= 1'b0;
                  rsp_dat_o     <= we_o ? '0 : dat_i;
                  state_reg     <= RESP;
               end else if ((TIMEOUT != 0) && (cnt_reg == CNT_LIMIT)) begin
                  cyc_o         <= 1'b0;
                  stb_o         <= 1'b0;
                  rsp_valid_o   <= 1'b1;
                  rsp_err_o     <= 1'b1;
                  rsp_timeout_o <= 1'b1;
                  rsp_dat_o     <= '0;
                  state_reg     <= RESP;
               end else if (cnt_reg != CNT_MAX) begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  state_reg   <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, Wishbone address width in bits (byte address).
REQ-002 Parameter DATA_WIDTH, default 32, Wishbone data width in bits; multiple of 8.
REQ-003 Parameter TIMEOUT, default 255, max cycles waited for ack_i/err_i; 0 disables timeout.
REQ-004 Port clk_i  input  1  single clock, all logic on rising edge.
REQ-005 Port rst_i  input  1  reset, synchronous, active-high.
REQ-006 Port cmd_valid_i  input  1  command request.
REQ-007 Port cmd_ready_o  output  1  command accepted when cmd_valid_i & cmd_ready_o.
REQ-008 Port cmd_we_i  input  1  1 = write, 0 = read.
REQ-009 Port cmd_adr_i  input  ADDR_WIDTH  byte address.
REQ-010 Port cmd_dat_i  input  DATA_WIDTH  write data.
REQ-011 Port cmd_sel_i  input  DATA_WIDTH/8  byte lane select.
REQ-012 Port rsp_valid_o  output  1  response available.
REQ-013 Port rsp_ready_i  input  1  response consumed when rsp_valid_o & rsp_ready_i.
REQ-014 Port rsp_dat_o  output  DATA_WIDTH  read data (0 for writes, errors, timeouts).
REQ-015 Port rsp_err_o  output  1  transfer terminated by err_i or timeout.
REQ-016 Port rsp_timeout_o  output  1  transfer terminated by timeout.
REQ-017 Ports cyc_o, stb_o, we_o (output 1), adr_o (output ADDR_WIDTH), dat_o (output DATA_WIDTH), sel_o (output DATA_WIDTH/8): Wishbone B4 classic master outputs.
REQ-018 Ports dat_i (input DATA_WIDTH), ack_i, err_i (input 1): Wishbone slave responses.

Function
REQ-019 FSM states SHALL be IDLE, BUS, RESP; all outputs registered except cmd_ready_o, which SHALL equal (state == IDLE).
REQ-020 IDLE: on cmd_valid_i at a rising edge, latch we/adr/dat/sel onto we_o/adr_o/dat_o/sel_o, set cyc_o=stb_o=1, clear timeout counter, go BUS.
REQ-021 First cycle of cyc_o/stb_o high SHALL be the cycle after command acceptance (1-cycle request latency).
REQ-022 BUS: cyc_o, stb_o, we_o, adr_o, dat_o, sel_o SHALL stay stable until termination.
REQ-023 BUS termination: ack_i or err_i sampled high, or counter == TIMEOUT (TIMEOUT != 0); counter increments each BUS cycle without termination, width $clog2(TIMEOUT+1), no wrap.
REQ-024 On termination edge: cyc_o=stb_o=0, go RESP, rsp_valid_o=1 next cycle (1-cycle response latency).
REQ-025 ack_i & err_i same cycle: error wins (rsp_err_o=1, rsp_dat_o=0).
REQ-026 ack_i or err_i on the same cycle the counter reaches TIMEOUT: bus response wins, rsp_timeout_o=0.
REQ-027 Read ack: rsp_dat_o=dat_i sampled on the ack edge; write ack: rsp_dat_o=0; rsp_err_o=rsp_timeout_o=0.
REQ-028 Timeout: rsp_err_o=1, rsp_timeout_o=1, rsp_dat_o=0.
REQ-029 RESP: rsp_* held stable while rsp_valid_o & !rsp_ready_i; on rsp_ready_i, rsp_valid_o=0 next cycle, go IDLE.
REQ-030 Max throughput: one transfer per 3 cycles plus slave wait states; no outstanding-transfer pipelining.
REQ-031 ack_i/err_i outside BUS SHALL be ignored.
REQ-032 cmd_* inputs outside IDLE SHALL be ignored.

Reset
REQ-033 rst_i high at a rising edge: state=IDLE, cyc_o=stb_o=we_o=0, adr_o=dat_o=sel_o=0, rsp_valid_o=rsp_err_o=rsp_timeout_o=0, rsp_dat_o=0, counter=0.
REQ-034 Reset mid-BUS or mid-RESP SHALL abort: cyc_o drops the cycle after the reset edge, pending response discarded.
REQ-035 cmd_ready_o SHALL be 0 while rst_i high.

Verification
REQ-036 Write adr 'h10, dat 'hDEADBEEF, sel 4'b0101, slave acks after 2 wait states -> cyc_o/stb_o high 3 cycles, we_o=1, sel_o=4'b0101; rsp_valid_o with rsp_err_o=0, rsp_dat_o=0.
REQ-037 Read adr 'h20, slave returns 'hCAFEF00D with 0 wait states -> rsp_dat_o='hCAFEF00D one cycle after ack, total 3 cycles accept-to-rsp_valid_o.
REQ-038 Slave never responds, TIMEOUT=255 -> cyc_o high exactly 256 cycles, then rsp_err_o=1, rsp_timeout_o=1, rsp_dat_o=0.
REQ-039 ack_i and err_i asserted together on a read -> rsp_err_o=1, rsp_timeout_o=0, rsp_dat_o=0.
REQ-040 rsp_ready_i held low 5 cycles, cmd_valid_i held high -> rsp_* stable, cmd_ready_o=0, no new cyc_o until response consumed.
REQ-041 rst_i pulsed during BUS -> cyc_o=0 next cycle, no rsp_valid_o, next command completes normally; 64 random masked writes then full readback match a byte-masked memory model.
